// File: rtl/midi_rx_parser.sv
// MIDI serial receiver that decodes Note-On/Note-Off messages into {on, note} events.
// A small FIFO and an output pacer hold each event on msg/clk_msg long enough for the player.
module midi_rx_parser #(
  parameter int CLK_FREQ    = 120_000_000,
  parameter int BAUD        = 31250,
  parameter int CHANNEL     = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] msg,
  output logic       clk_msg,
  output logic       frame_err,
  output logic       overrun
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PMAX       = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PW         = $clog2(PMAX + 1);
  localparam logic [3:0] CH = 4'(CHANNEL);

  // rx_d is one more stage behind rx_s2 so IDLE can see a clean 1->0 edge
  logic rx_s1, rx_s2, rx_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  ustate_t         us;
  logic [CW-1:0]   ucnt;
  logic [2:0]      bitn;
  logic [7:0]      shreg;
  logic            bit_end, stop_smp, byte_vld;

  assign bit_end  = (ucnt == CW'(BIT_CYCLES - 1));
  assign stop_smp = (us == U_STOP) && bit_end;
  assign byte_vld = stop_smp && rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      us        <= U_IDLE;
      ucnt      <= '0;
      bitn      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_smp && !rx_s2;
      ucnt      <= ucnt + CW'(1);
      case (us)
        U_IDLE: begin
          ucnt <= '0;
          if (rx_d && !rx_s2) us <= U_START;
        end
        U_START: if (ucnt == CW'(HALF - 1)) begin
          ucnt <= '0;
          bitn <= '0;
          us   <= rx_s2 ? U_IDLE : U_DATA;
        end
        U_DATA: if (bit_end) begin
          ucnt  <= '0;
          shreg <= {rx_s2, shreg[7:1]};
          bitn  <= bitn + 3'd1;
          if (bitn == 3'd7) us <= U_STOP;
        end
        U_STOP: if (bit_end) begin
          ucnt <= '0;
          us   <= U_IDLE;
        end
        default: us <= U_IDLE;
      endcase
    end
  end

  typedef enum logic [1:0] {P_IGNORE, P_KEY, P_VEL} pstate_t;
  pstate_t    ps;
  logic       on_flag;
  logic [6:0] key;
  logic       push, ch_ok;
  logic [7:0] ev;

  assign ch_ok = (CHANNEL == 16) || (shreg[3:0] == CH);
  assign push  = byte_vld && (ps == P_VEL) && !shreg[7] && (key != 7'd0);
  assign ev    = {on_flag && (shreg[6:0] != 7'd0), key};

  always_ff @(posedge clk) begin
    if (rst) begin
      ps      <= P_IGNORE;
      on_flag <= 1'b0;
      key     <= '0;
    end else if (byte_vld) begin
      if (shreg[7]) begin
        // realtime bytes (F8..FF) leave running status untouched
        if (shreg[7:3] != 5'b11111) begin
          if (shreg[7:5] == 3'b100 && ch_ok) begin
            on_flag <= shreg[4];
            ps      <= P_KEY;
          end else begin
            ps <= P_IGNORE;
          end
        end
      end else begin
        case (ps)
          P_KEY: begin
            key <= shreg[6:0];
            ps  <= P_VEL;
          end
          P_VEL:   ps <= P_KEY;
          default: ps <= P_IGNORE;
        endcase
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, empty, wr, pop;

  typedef enum logic [1:0] {Q_IDLE, Q_LOAD, Q_HOLD, Q_GAP} qstate_t;
  qstate_t       qs;
  logic [PW-1:0] pcnt;

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  // a pop never makes room for a push in the same cycle when full
  assign wr    = push && !full;
  assign pop   = (qs == Q_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full;
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      case ({wr, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qs      <= Q_IDLE;
      pcnt    <= '0;
      msg     <= '0;
      clk_msg <= 1'b0;
    end else begin
      case (qs)
        Q_IDLE: if (!empty) begin
          msg <= mem[rp];
          qs  <= Q_LOAD;
        end
        Q_LOAD: begin
          clk_msg <= 1'b1;
          pcnt    <= '0;
          qs      <= Q_HOLD;
        end
        Q_HOLD: if (pcnt == PW'(HOLD_CYCLES - 1)) begin
          clk_msg <= 1'b0;
          pcnt    <= '0;
          qs      <= Q_GAP;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
        Q_GAP: if (pcnt == PW'(GAP_CYCLES - 1)) qs <= Q_IDLE;
               else pcnt <= pcnt + PW'(1);
        default: qs <= Q_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_midi_rx_parser.sv
// Directed bench for midi_rx_parser: omni, channel-2 and long-hold instances share one rx line.
module tb_midi_rx_parser;
  localparam int BITC = 16;
  localparam int CLKF = 31250 * BITC;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] m_msg, c_msg, o_msg;
  logic m_clk, c_clk, o_clk, m_fe, c_fe, o_fe, m_ov, c_ov, o_ov;

  midi_rx_parser #(.CLK_FREQ(CLKF), .BAUD(31250)) u_main (
    .clk(clk), .rst(rst), .rx(rx), .msg(m_msg), .clk_msg(m_clk), .frame_err(m_fe), .overrun(m_ov));
  midi_rx_parser #(.CLK_FREQ(CLKF), .BAUD(31250), .CHANNEL(2)) u_ch2 (
    .clk(clk), .rst(rst), .rx(rx), .msg(c_msg), .clk_msg(c_clk), .frame_err(c_fe), .overrun(c_ov));
  midi_rx_parser #(.CLK_FREQ(CLKF), .BAUD(31250), .HOLD_CYCLES(8000)) u_ovr (
    .clk(clk), .rst(rst), .rx(rx), .msg(o_msg), .clk_msg(o_clk), .frame_err(o_fe), .overrun(o_ov));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int last_start;

  logic       m_clk_q = 1'b0, c_clk_q = 1'b0, o_clk_q = 1'b0;
  logic [7:0] m_msg_q = 8'h00;
  logic [7:0] m_evq[$], c_evq[$], o_evq[$];
  int m_chg = 0, m_rise = 0, m_fall = -1000, m_hi = 0, m_lo = 0;
  int m_fe_n = 0, m_ov_n = 0, m_unstable = 0, o_ov_n = 0;

  always @(negedge clk) begin
    if (m_msg !== m_msg_q) begin
      m_chg = cyc;
      if (m_clk && m_clk_q) m_unstable++;
    end
    if (m_clk && !m_clk_q) begin
      m_evq.push_back(m_msg);
      m_rise = cyc;
      m_lo   = cyc - m_fall;
    end
    if (!m_clk && m_clk_q) begin
      m_fall = cyc;
      m_hi   = cyc - m_rise;
    end
    if (m_fe) m_fe_n++;
    if (m_ov) m_ov_n++;
    m_clk_q = m_clk;
    m_msg_q = m_msg;
  end

  always @(negedge clk) begin
    if (c_clk && !c_clk_q) c_evq.push_back(c_msg);
    if (o_clk && !o_clk_q) o_evq.push_back(o_msg);
    if (o_ov) o_ov_n++;
    c_clk_q = c_clk;
    o_clk_q = o_clk;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk); #1;
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BITC) @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    m_evq.delete();
    c_evq.delete();
    m_fe_n = 0;
    m_ov_n = 0;
    m_unstable = 0;
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (m_msg !== 8'h00) $display("FAIL reset_msg: got %h want 00", m_msg); else n_pass++;
    n_chk++; if (m_clk !== 1'b0) $display("FAIL reset_clk_msg: got %b want 0", m_clk); else n_pass++;
    n_chk++; if ({m_fe, c_fe, o_fe} !== 3'b000) $display("FAIL reset_frame_err: got %b want 000", {m_fe, c_fe, o_fe}); else n_pass++;
    n_chk++; if ({m_ov, c_ov, o_ov} !== 3'b000) $display("FAIL reset_overrun: got %b want 000", {m_ov, c_ov, o_ov}); else n_pass++;
    n_chk++; if ({c_msg, o_msg} !== 16'h0000) $display("FAIL reset_msg_other: got %h want 0000", {c_msg, o_msg}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_note_on();
    int s;
    clr();
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    // stop-bit midpoint sits ~152 cycles after the start edge; two-flop sync adds delay
    s = last_start;
    settle();
    n_chk++; if (m_evq.size() !== 1) $display("FAIL on_count: got %0d want 1", m_evq.size()); else n_pass++;
    n_chk++; if (m_evq[0] !== 8'hBC) $display("FAIL on_value: got %h want bc", m_evq[0]); else n_pass++;
    n_chk++; if (m_chg - s < 152 || m_chg - s > 160) $display("FAIL on_latency: got %0d want 152..160", m_chg - s); else n_pass++;
    n_chk++; if (m_rise !== m_chg + 1) $display("FAIL on_strobe_delay: got %0d want %0d", m_rise, m_chg + 1); else n_pass++;
    n_chk++; if (m_hi !== 4) $display("FAIL on_hold: got %0d want 4", m_hi); else n_pass++;
    n_chk++; if (m_fe_n + m_ov_n !== 0) $display("FAIL on_errors: got %0d want 0", m_fe_n + m_ov_n); else n_pass++;
  endtask

  task automatic test_running_status();
    clr();
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
    settle();
    n_chk++; if (m_evq.size() !== 2) $display("FAIL rs_count: got %0d want 2", m_evq.size()); else n_pass++;
    n_chk++; if (m_evq[0] !== 8'hBC) $display("FAIL rs_first: got %h want bc", m_evq[0]); else n_pass++;
    n_chk++; if (m_evq[1] !== 8'h3C) $display("FAIL rs_second: got %h want 3c", m_evq[1]); else n_pass++;
    n_chk++; if (m_lo < 4) $display("FAIL rs_gap: got %0d want >=4", m_lo); else n_pass++;
    n_chk++; if (m_unstable !== 0) $display("FAIL rs_msg_stable: got %0d want 0", m_unstable); else n_pass++;
  endtask

  task automatic test_note_off_filter();
    clr();
    send_byte(8'h80, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h10, 1'b1);
    settle();
    n_chk++; if (m_evq.size() !== 1 || m_evq[0] !== 8'h40) $display("FAIL off_event: got n=%0d %h want n=1 40", m_evq.size(), m_evq[0]); else n_pass++;
    clr();
    send_byte(8'h91, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h64, 1'b1);
    settle();
    n_chk++; if (c_evq.size() !== 0) $display("FAIL ch2_reject: got %0d want 0", c_evq.size()); else n_pass++;
    n_chk++; if (m_evq.size() !== 1 || m_evq[0] !== 8'hC0) $display("FAIL omni_accept: got n=%0d %h want n=1 c0", m_evq.size(), m_evq[0]); else n_pass++;
    clr();
    send_byte(8'h92, 1'b1); send_byte(8'h41, 1'b1); send_byte(8'h64, 1'b1);
    settle();
    n_chk++; if (c_evq.size() !== 1 || c_evq[0] !== 8'hC1) $display("FAIL ch2_accept: got n=%0d %h want n=1 c1", c_evq.size(), c_evq[0]); else n_pass++;
    clr();
    send_byte(8'h90, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h64, 1'b1);
    settle();
    n_chk++; if (m_evq.size() !== 0) $display("FAIL key0_dropped: got %0d want 0", m_evq.size()); else n_pass++;
  endtask

  task automatic test_realtime();
    clr();
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h64, 1'b1);
    settle();
    n_chk++; if (m_evq.size() !== 1 || m_evq[0] !== 8'hBC) $display("FAIL rt_event: got n=%0d %h want n=1 bc", m_evq.size(), m_evq[0]); else n_pass++;
    clr();
    send_byte(8'hB0, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h7F, 1'b1);
    settle();
    n_chk++; if (m_evq.size() !== 0) $display("FAIL cc_ignored: got %0d want 0", m_evq.size()); else n_pass++;
  endtask

  task automatic test_frame_glitch();
    clr();
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b0);
    settle();
    rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_chk++; if (m_fe_n !== 1) $display("FAIL fe_pulse: got %0d want 1", m_fe_n); else n_pass++;
    n_chk++; if (m_evq.size() !== 0) $display("FAIL fe_no_event: got %0d want 0", m_evq.size()); else n_pass++;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    n_chk++; if (m_fe_n !== 1 || m_evq.size() !== 0) $display("FAIL glitch_quiet: got fe=%0d ev=%0d want 1 0", m_fe_n, m_evq.size()); else n_pass++;
    // parser must still be waiting for the velocity of key 0x3C
    send_byte(8'h64, 1'b1);
    settle();
    n_chk++; if (m_evq.size() !== 1 || m_evq[0] !== 8'hBC) $display("FAIL glitch_no_byte: got n=%0d %h want n=1 bc", m_evq.size(), m_evq[0]); else n_pass++;
  endtask

  task automatic test_overrun_reset();
    int t;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    o_evq.delete();
    o_ov_n = 0;
    send_byte(8'h90, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h31 + 8'(i), 1'b1);
      send_byte(8'h40, 1'b1);
    end
    t = 0;
    while (o_evq.size() < 5 && t < 50000) begin
      @(posedge clk);
      t++;
    end
    n_chk++; if (o_evq.size() !== 5) $display("FAIL ovr_delivered: got %0d want 5", o_evq.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (o_evq[i] !== (8'hB1 + 8'(i))) $display("FAIL ovr_order%0d: got %h want %h", i, o_evq[i], 8'hB1 + 8'(i));
      else n_pass++;
    end
    n_chk++; if (o_ov_n !== 1) $display("FAIL ovr_pulse: got %0d want 1", o_ov_n); else n_pass++;
    repeat (8100) @(posedge clk);
    @(negedge clk);
    n_chk++; if (o_evq.size() !== 5) $display("FAIL ovr_dropped: got %0d want 5", o_evq.size()); else n_pass++;
    send_byte(8'h37, 1'b1); send_byte(8'h40, 1'b1);
    t = 0;
    while (o_clk !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_chk++; if (o_clk !== 1'b1 || o_msg !== 8'hB7) $display("FAIL rst_strobe_seen: got %b %h want 1 b7", o_clk, o_msg); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (o_clk !== 1'b0 || o_msg !== 8'h00) $display("FAIL rst_abort: got %b %h want 0 00", o_clk, o_msg); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_note_off_filter();
    test_realtime();
    test_frame_glitch();
    test_overrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/midi_rx_parser.md
Name: midi_rx_parser

Overview:
- Upstream stage of the polyphonic player: receives a serial MIDI stream on one pin and decodes Note-On and Note-Off messages.
- Each decoded event is presented on the player's message interface: msg, with msg[7] = 1 for on / 0 for off and msg[6:0] = note, qualified by a rising edge on clk_msg.
- A small event FIFO and an output pacer guarantee each event is held long enough for the player's slot-search state machine to finish.

Parameters:
- CLK_FREQ, 120_000_000: system clock frequency in Hz.
- BAUD, 31250: serial bit rate. BIT_CYCLES = CLK_FREQ/BAUD (integer division; 3840 at the defaults).
- CHANNEL, 16: MIDI channel filter. Values 0..15 accept only that channel; 16 accepts all channels (omni).
- FIFO_DEPTH, 4: number of event entries. Must be a power of two, 2 or larger.
- HOLD_CYCLES, 4: number of cycles clk_msg stays high per event.
- GAP_CYCLES, 4: minimum number of clk_msg-low cycles between events. HOLD_CYCLES+GAP_CYCLES must be at least PLAYER_NUM+2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous MIDI serial input; idles high.
- msg  output  8  event to the player: {on/off, note[6:0]}.
- clk_msg  output  1  event strobe; the player samples msg on its rising edge.
- frame_err  output  1  one-cycle pulse when a received stop bit is 0.
- overrun  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high):
  - msg=0, clk_msg=0, frame_err=0, overrun=0.
  - FIFO empty, running status cleared (parser in IGNORE), UART in IDLE, pacer in IDLE.
  - Asserting rst mid-byte or mid-strobe aborts the operation; the partial byte is not delivered.
- Input synchronizer: two flip-flops on rx, reset value 1. All UART logic uses the synchronized value.
- UART receiver, 8N1, LSB first; states IDLE, START, DATA, STOP:
  - IDLE -> START on a synchronized 1->0 transition.
  - START: wait BIT_CYCLES/2, then re-sample. If rx=1 the start was a glitch: go to IDLE with no error.
  - DATA: sample 8 bits, one every BIT_CYCLES.
  - STOP: sample one more bit BIT_CYCLES later; this sample cycle is S.
  - Stop bit = 1: the byte is valid to the parser at S. Stop bit = 0: the byte is discarded and frame_err pulses at S+1.
  - In both cases the receiver returns to IDLE at S+1 and can accept a new start edge at S+1.
- Parser; states IGNORE, NOTE_KEY, NOTE_VEL:
  - 0xF8..0xFF (realtime): ignored; state and running status are unchanged.
  - 0xF0..0xF7: go to IGNORE.
  - 0x8n / 0x9n where n matches CHANNEL (or CHANNEL=16): latch on_flag (1 for 0x9n), go to NOTE_KEY.
  - Any other status 0x80..0xEF: go to IGNORE.
  - Data byte (bit7=0) in IGNORE: dropped.
  - Data byte in NOTE_KEY: latch key, go to NOTE_VEL.
  - Data byte in NOTE_VEL: emit an event, then return to NOTE_KEY (running status).
- Event rules:
  - Event is {1,key} if on_flag=1 and velocity is nonzero; otherwise {0,key}.
  - key=0 is never emitted, because the player reserves 0 as an empty slot.
  - The event is pushed into the FIFO at S+1.
  - If the FIFO is full at push, the event is dropped, overrun pulses at S+1, and FIFO contents are unchanged.
- Pacer; states IDLE, LOAD, HOLD, GAP:
  - IDLE with FIFO non-empty: pop the head and drive msg with it on the next edge (LOAD).
  - clk_msg rises one cycle after msg changes, stays high HOLD_CYCLES, then stays low for GAP_CYCLES.
  - After GAP, return to IDLE.
  - msg is held until the next load and never changes while clk_msg is high.
  - Zero-wait latency: with FIFO empty and pacer idle, msg updates at S+2 and clk_msg rises at S+3.
- FIFO: circular buffer with pointers wrapping modulo FIFO_DEPTH.
  - Simultaneous push and pop in the same cycle are both honoured.
  - When full, a pop in the same cycle as a push does not free space for that push; the push is dropped.
  - Occupancy counter width is log2(FIFO_DEPTH)+1.

Test Plan:
- Send bytes 0x90 0x3C 0x64 -> msg=0xBC appears at S+2 and clk_msg is high for 4 cycles starting at S+3; no error pulses.
- Running status: send 0x90 0x3C 0x64 0x3C 0x00 -> two events, 0xBC then 0x3C, separated by at least 4 clk_msg-low cycles.
- Note-off and filtering:
  - Send 0x80 0x40 0x10 -> event 0x40.
  - With CHANNEL=2, send 0x91 0x40 0x64 -> no event.
  - Send 0x90 0x00 0x64 -> no event.
- Realtime interleaving: send 0x90 0x3C 0xF8 0x64 -> single event 0xBC. Then 0xB0 0x07 0x7F -> no event.
- Corrupt frame and glitch:
  - Stop bit forced to 0 on the velocity byte -> frame_err pulses once and no event is emitted.
  - A rx low pulse shorter than BIT_CYCLES/2 -> no byte and no error.
- Overrun and reset: bench overrides HOLD_CYCLES=8000 and pushes 6 events back-to-back -> first 5 delivered in order (1 loaded into the pacer, 4 held in the FIFO), overrun pulses once. Then assert rst during a strobe -> clk_msg=0 and msg=0 on the next cycle.
